// File: rtl/hash_index_issue_stage_pkg.sv
// Shared opt encodings, default widths and the Fibonacci hash constant for the
// hash-index issue stage and its read-side siblings.
package hash_index_issue_stage_pkg;

    localparam int DEF_INDEX_WIDTH = 12;
    localparam int DEF_VALUE_WIDTH = 31;
    localparam int DEF_KEY_WIDTH   = 32;
    localparam int DEF_HAZ_DEPTH   = 8;

    localparam logic [31:0] DEF_HASH_MULT = 32'h9E3779B1;

    typedef enum logic [1:0] {
        OPT_READ  = 2'b00,
        OPT_WRITE = 2'b01,
        OPT_RSVD  = 2'b10,
        OPT_DEL   = 2'b11
    } opt_e;

    // Only writes and deletes change bank contents; the reserved code behaves as a read.
    function automatic logic is_mutating(input logic [1:0] opt);
        return (opt == OPT_WRITE) || (opt == OPT_DEL);
    endfunction

endpackage

// File: rtl/hash_index_issue_stage_if.sv
// Request-side valid/ready link carrying key, value and opt into the issue stage.
interface hash_index_issue_stage_if
    import hash_index_issue_stage_pkg::*;
#(
    parameter int KEY_WIDTH   = DEF_KEY_WIDTH,
    parameter int VALUE_WIDTH = DEF_VALUE_WIDTH
);
    logic                   in_valid;
    logic                   in_ready;
    logic [KEY_WIDTH-1:0]   in_key;
    logic [VALUE_WIDTH-1:0] in_value;
    logic [1:0]             in_opt;

    modport master (
        output in_valid,
        output in_key,
        output in_value,
        output in_opt,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_key,
        input  in_value,
        input  in_opt,
        output in_ready
    );

endinterface

// File: rtl/hash_index_issue_stage_fib_hash_pipe.sv
// Two-register multiplicative hash pipe (H1 partial products, H2 index) with a
// hold input that freezes both registers while the consumer stalls.
module fib_hash_pipe
    import hash_index_issue_stage_pkg::*;
#(
    parameter int                   INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int                   VALUE_WIDTH = DEF_VALUE_WIDTH,
    parameter int                   KEY_WIDTH   = DEF_KEY_WIDTH,
    parameter logic [KEY_WIDTH-1:0] HASH_MULT   = KEY_WIDTH'(DEF_HASH_MULT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hold_i,
    input  logic                   valid_i,
    input  logic [KEY_WIDTH-1:0]   key_i,
    input  logic [VALUE_WIDTH-1:0] value_i,
    input  logic [1:0]             opt_i,
    output logic                   valid_o,
    output logic [INDEX_WIDTH-1:0] index_o,
    output logic [KEY_WIDTH-1:0]   key_o,
    output logic [VALUE_WIDTH-1:0] value_o,
    output logic [1:0]             opt_o
);

    logic                   h1_valid_q, h1_valid_d;
    logic [KEY_WIDTH-1:0]   h1_key_q,   h1_key_d;
    logic [VALUE_WIDTH-1:0] h1_value_q, h1_value_d;
    logic [1:0]             h1_opt_q,   h1_opt_d;
    logic [KEY_WIDTH-1:0]   h1_lo_q,    h1_lo_d;
    logic [KEY_WIDTH-1:0]   h1_hi_q,    h1_hi_d;

    logic                   h2_valid_q, h2_valid_d;
    logic [INDEX_WIDTH-1:0] h2_index_q, h2_index_d;
    logic [KEY_WIDTH-1:0]   h2_key_q,   h2_key_d;
    logic [VALUE_WIDTH-1:0] h2_value_q, h2_value_d;
    logic [1:0]             h2_opt_q,   h2_opt_d;

    logic [KEY_WIDTH-1:0]   key_lo_ext;
    logic [KEY_WIDTH-1:0]   key_hi_ext;
    logic [KEY_WIDTH-1:0]   product;

    // Splitting the key into 16-bit halves keeps each multiplier DSP-sized.
    assign key_lo_ext = {{(KEY_WIDTH-16){1'b0}}, key_i[15:0]};
    assign key_hi_ext = {16'b0, key_i[KEY_WIDTH-1:16]};
    assign product    = h1_lo_q + (h1_hi_q << 16);

    always_comb begin
        h1_valid_d = h1_valid_q;
        h1_key_d   = h1_key_q;
        h1_value_d = h1_value_q;
        h1_opt_d   = h1_opt_q;
        h1_lo_d    = h1_lo_q;
        h1_hi_d    = h1_hi_q;
        h2_valid_d = h2_valid_q;
        h2_index_d = h2_index_q;
        h2_key_d   = h2_key_q;
        h2_value_d = h2_value_q;
        h2_opt_d   = h2_opt_q;
        if (!hold_i) begin
            h1_valid_d = valid_i;
            h1_key_d   = key_i;
            h1_value_d = value_i;
            h1_opt_d   = opt_i;
            h1_lo_d    = key_lo_ext * HASH_MULT;
            h1_hi_d    = key_hi_ext * HASH_MULT;
            h2_valid_d = h1_valid_q;
            h2_index_d = product[KEY_WIDTH-1 -: INDEX_WIDTH];
            h2_key_d   = h1_key_q;
            h2_value_d = h1_value_q;
            h2_opt_d   = h1_opt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h1_valid_q <= 1'b0;
            h2_valid_q <= 1'b0;
        end else begin
            h1_valid_q <= h1_valid_d;
            h2_valid_q <= h2_valid_d;
        end
        h1_key_q   <= h1_key_d;
        h1_value_q <= h1_value_d;
        h1_opt_q   <= h1_opt_d;
        h1_lo_q    <= h1_lo_d;
        h1_hi_q    <= h1_hi_d;
        h2_index_q <= h2_index_d;
        h2_key_q   <= h2_key_d;
        h2_value_q <= h2_value_d;
        h2_opt_q   <= h2_opt_d;
    end

    assign valid_o = h2_valid_q;
    assign index_o = h2_index_q;
    assign key_o   = h2_key_q;
    assign value_o = h2_value_q;
    assign opt_o   = h2_opt_q;

endmodule

// File: rtl/hash_index_issue_stage.sv
// Hashes table requests, holds back any request whose index collides with a
// recent write/delete, and issues the survivors in order to the URAM stage.
module hash_index_issue_stage
    import hash_index_issue_stage_pkg::*;
#(
    parameter int                   INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int                   VALUE_WIDTH = DEF_VALUE_WIDTH,
    parameter int                   KEY_WIDTH   = DEF_KEY_WIDTH,
    parameter logic [KEY_WIDTH-1:0] HASH_MULT   = KEY_WIDTH'(DEF_HASH_MULT),
    parameter int                   HAZ_DEPTH   = DEF_HAZ_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    hash_index_issue_stage_if.slave  req,
    output logic [INDEX_WIDTH-1:0]   index_out,
    output logic [KEY_WIDTH-1:0]     key_out,
    output logic [VALUE_WIDTH-1:0]   value_out,
    output logic [1:0]               opt_out,
    output logic                     en_out,
    output logic [15:0]              stall_count
);

    // A write occupies HAZ_DEPTH consecutive issue slots: its own plus the next
    // HAZ_DEPTH-1. The candidate's own slot is implicit, so only the HAZ_DEPTH-1
    // most recent issue slots (slot 0 being the output register) are compared.
    localparam int NWIN = HAZ_DEPTH - 1;

    logic                   h3_valid;
    logic [INDEX_WIDTH-1:0] h3_index;
    logic [KEY_WIDTH-1:0]   h3_key;
    logic [VALUE_WIDTH-1:0] h3_value;
    logic [1:0]             h3_opt;

    logic                   hazard;
    logic                   issue;

    logic [NWIN-1:0]                  win_valid;
    logic [NWIN-1:0][INDEX_WIDTH-1:0] win_index;
    logic [NWIN-1:0]                  win_match;
    logic [NWIN-1:1]                  win_valid_q;
    logic [INDEX_WIDTH-1:0]           win_index_q [1:NWIN-1];

    logic                   en_out_q,    en_out_d;
    logic [INDEX_WIDTH-1:0] index_out_q, index_out_d;
    logic [KEY_WIDTH-1:0]   key_out_q,   key_out_d;
    logic [VALUE_WIDTH-1:0] value_out_q, value_out_d;
    logic [1:0]             opt_out_q,   opt_out_d;
    logic [15:0]            stall_cnt_q, stall_cnt_d;

    fib_hash_pipe #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .VALUE_WIDTH (VALUE_WIDTH),
        .KEY_WIDTH   (KEY_WIDTH),
        .HASH_MULT   (HASH_MULT)
    ) u_hash (
        .clk     (clk),
        .reset   (reset),
        .hold_i  (hazard),
        .valid_i (req.in_valid && req.in_ready),
        .key_i   (req.in_key),
        .value_i (req.in_value),
        .opt_i   (req.in_opt),
        .valid_o (h3_valid),
        .index_o (h3_index),
        .key_o   (h3_key),
        .value_o (h3_value),
        .opt_o   (h3_opt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NWIN; gi++) begin : g_win
            if (gi == 0) begin : g_head
                assign win_valid[gi] = en_out_q && is_mutating(opt_out_q);
                assign win_index[gi] = index_out_q;
            end else begin : g_tail
                assign win_valid[gi] = win_valid_q[gi];
                assign win_index[gi] = win_index_q[gi];
            end
            assign win_match[gi] = win_valid[gi] && (win_index[gi] == h3_index);
        end
    endgenerate

    assign hazard       = h3_valid && (|win_match);
    assign issue        = h3_valid && !hazard;
    assign req.in_ready = !hazard;

    // Stall cycles put no issue on the output, so an invalid slot shifts in.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_valid_q <= '0;
        end else begin
            win_valid_q <= win_valid[NWIN-2:0];
        end
        for (int i = 1; i < NWIN; i++) begin
            win_index_q[i] <= win_index[i-1];
        end
    end

    always_comb begin
        en_out_d    = issue;
        index_out_d = index_out_q;
        key_out_d   = key_out_q;
        value_out_d = value_out_q;
        opt_out_d   = opt_out_q;
        stall_cnt_d = stall_cnt_q;
        if (issue) begin
            index_out_d = h3_index;
            key_out_d   = h3_key;
            value_out_d = h3_value;
            opt_out_d   = h3_opt;
        end
        if (hazard && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_out_q    <= 1'b0;
            index_out_q <= '0;
            key_out_q   <= '0;
            value_out_q <= '0;
            opt_out_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            en_out_q    <= en_out_d;
            index_out_q <= index_out_d;
            key_out_q   <= key_out_d;
            value_out_q <= value_out_d;
            opt_out_q   <= opt_out_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign en_out      = en_out_q;
    assign index_out   = index_out_q;
    assign key_out     = key_out_q;
    assign value_out   = value_out_q;
    assign opt_out     = opt_out_q;
    assign stall_count = stall_cnt_q;

endmodule
